fs_using_hs: RTL and testbench
==============================

# fs_using_hs

Registered full subtractor built from two half subtractors and an OR gate, widened by parameter into a ripple-borrow chain. It computes a − b − borrow-in and returns the difference and borrow-out one clock after sampling. It is a leaf arithmetic block used in datapaths that need a registered subtract stage. With default parameters it is the classic 1-bit full subtractor.

## Interface
- WIDTH, default 1 — operand width in bits; legal range is 1 to 64.
- clk  input  1  — rising-edge clock.
- rst  input  1  — synchronous, active-high reset.
- a  input  WIDTH  — minuend.
- b  input  WIDTH  — subtrahend.
- bout  input  1  — borrow into bit 0. The name is historical; this port is the borrow *input*.
- valid_in  input  1  — qualifies a, b and bout this cycle.
- diff  output  WIDTH  — registered difference.
- bin  output  1  — registered borrow out of the MSB. The name is historical; this port is the borrow *output*.
- valid_out  output  1  — diff and bin hold the result of a valid_in beat.

## Operation
- Half subtractor cell (internal submodule): d = x ^ y; br = ~x & y.
- Full subtractor bit i:
  - HS1(a[i], b[i]) gives d1 and br1.
  - HS2(d1, c[i]) gives diff bit i and br2.
  - c[i+1] = br1 | br2.
  - c[0] = bout.
- Equivalent per bit:
  - diff[i] = a[i] ^ b[i] ^ c[i].
  - c[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i]).
- Word result:
  - diff = (a − b − bout) mod 2^WIDTH, unsigned.
  - bin = c[WIDTH] = 1 iff a < b + bout, treating a, b and bout as unsigned integers.
- The ripple chain is purely combinational. Only diff, bin and valid_out are registered.
- When valid_in = 0, diff and bin hold their previous values and valid_out goes to 0 on that edge.
- No X-propagation masking: unknown inputs with valid_in = 1 may produce unknown outputs.

## Timing
- All state updates on the rising edge of clk.
- Latency is 1 cycle: inputs sampled at edge N appear on diff, bin and valid_out after edge N.
- Throughput is one operation per cycle; back-to-back valid_in beats are allowed with no bubbles.
- Reset values: diff = 0, bin = 0, valid_out = 0.
- Reset is synchronous:
  - Takes effect at the first rising edge with rst = 1.
  - Inputs presented during reset are discarded.
  - No result is produced for them.
- Reset asserted while a beat is in flight: that result is lost and the outputs show reset values.
- First edge after rst deasserts: normal sampling resumes and valid_in is honoured.
- Boundaries:
  - a = 0, b = all-ones, bout = 1 → diff = 0, bin = 1.
  - a = b, bout = 0 → diff = 0, bin = 0.
  - a = b, bout = 1 → diff = all-ones, bin = 1.
- No combinational path from any input to any output.

## Test plan
- Reset: hold rst = 1 for 2 cycles with valid_in = 1 and a = b = bout = 1 → diff = 0, bin = 0, valid_out = 0 throughout, and one cycle after release.
- Exhaustive 1-bit truth table, WIDTH = 1, valid_in = 1, inputs (a, b, bout) → outputs (diff, bin) one cycle later:
  - 000 → 0, 0
  - 001 → 1, 1
  - 010 → 1, 1
  - 011 → 0, 1
  - 100 → 1, 0
  - 101 → 0, 0
  - 110 → 0, 0
  - 111 → 1, 1
- Streaming, WIDTH = 1: apply the 8 combinations on consecutive cycles → same results appear on consecutive cycles, with valid_out high for exactly 8 cycles.
- Hold, WIDTH = 1:
  - Apply 001 with valid_in = 1, then valid_in = 0 with inputs 100.
  - Required: diff = 1 and bin = 1 persist; valid_out = 0 on the second cycle.
- Wide ripple, WIDTH = 8:
  - a = 0x00, b = 0xFF, bout = 1 → diff = 0x00, bin = 1.
  - a = 0x80, b = 0x01, bout = 0 → diff = 0x7F, bin = 0.
  - Random 1000 beats are checked against (a − b − bout) mod 256 and a < b + bout.
- Mid-operation reset: valid beat at edge N, rst = 1 at edge N+1 → outputs are 0 after edge N+1, and the beat's result is never presented.

Source files
------------

// File: rtl/fs_using_hs.sv
// Registered ripple-borrow subtractor: diff/bin = a - b - bout, one cycle after sampling.
// Each bit is a full subtractor made of two half-subtractor cells and an OR gate.

module fs_hs_cell (
  input  logic x,
  input  logic y,
  output logic d,
  output logic br
);

  assign d  = x ^ y;
  assign br = ~x & y;

endmodule

module fs_using_hs #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bout,
  input  logic             valid_in,
  output logic [WIDTH-1:0] diff,
  output logic             bin,
  output logic             valid_out
);

  logic [WIDTH-1:0] diff_c;
  logic             borrow_msb;

  // Per-bit borrow wires live inside each generate block so the chain is
  // not one self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic c_in;
    logic d1;
    logic br1;
    logic br2;
    logic c_out;

    if (i == 0) begin : g_lsb
      assign c_in = bout;
    end else begin : g_upper
      assign c_in = g_bit[i-1].c_out;
    end

    fs_hs_cell u_hs1 (
      .x  (a[i]),
      .y  (b[i]),
      .d  (d1),
      .br (br1)
    );

    fs_hs_cell u_hs2 (
      .x  (d1),
      .y  (c_in),
      .d  (diff_c[i]),
      .br (br2)
    );

    assign c_out = br1 | br2;
  end

  assign borrow_msb = g_bit[WIDTH-1].c_out;

  // Result registers hold across idle cycles; only valid_out drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff      <= '0;
      bin       <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        diff <= diff_c;
        bin  <= borrow_msb;
      end
    end
  end

endmodule

// File: tb/tb_fs_using_hs.sv
// Self-checking bench for fs_using_hs at WIDTH=1 and WIDTH=8 against an
// arithmetic reference model of a - b - bout.

module tb_fs_using_hs;

  logic       clk = 1'b0;
  logic       rst;
  logic       a1, b1, bo1, v1;
  logic       diff1, bin1, vout1;
  logic [7:0] a8, b8;
  logic       bo8, v8;
  logic [7:0] diff8;
  logic       bin8, vout8;

  int checks = 0;
  int errors = 0;
  int v1_count = 0;

  // Reference model state: what the registered outputs must show.
  logic       m1_diff, m1_bin, m1_v;
  logic [7:0] m8_diff;
  logic       m8_bin, m8_v;

  always #5 clk = ~clk;

  fs_using_hs #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .a         (a1),
    .b         (b1),
    .bout      (bo1),
    .valid_in  (v1),
    .diff      (diff1),
    .bin       (bin1),
    .valid_out (vout1)
  );

  fs_using_hs #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .a         (a8),
    .b         (b8),
    .bout      (bo8),
    .valid_in  (v8),
    .diff      (diff8),
    .bin       (bin8),
    .valid_out (vout8)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {borrow, diff}: integer subtraction, wrapped to w bits.
  function automatic logic [8:0] sub_ref(input int w, input int av, input int bv, input int bov);
    int r;
    logic [8:0] res;
    r = av - bv - bov;
    res[7:0] = 8'(r & ((1 << w) - 1));
    res[8]   = (r < 0);
    return res;
  endfunction

  task automatic cycle(input logic r,
                       input logic va, input logic aa, input logic ba, input logic boa,
                       input logic vb, input logic [7:0] ab, input logic [7:0] bb,
                       input logic bob);
    logic [8:0] res;
    rst = r;
    v1 = va; a1 = aa; b1 = ba; bo1 = boa;
    v8 = vb; a8 = ab; b8 = bb; bo8 = bob;
    @(posedge clk);
    if (r) begin
      m1_diff = 1'b0; m1_bin = 1'b0; m1_v = 1'b0;
      m8_diff = 8'h00; m8_bin = 1'b0; m8_v = 1'b0;
    end else begin
      m1_v = va;
      if (va) begin
        res = sub_ref(1, int'(aa), int'(ba), int'(boa));
        m1_diff = res[0];
        m1_bin  = res[8];
      end
      m8_v = vb;
      if (vb) begin
        res = sub_ref(8, int'(ab), int'(bb), int'(bob));
        m8_diff = res[7:0];
        m8_bin  = res[8];
      end
    end
    #1;
    if (vout1 === 1'b1) v1_count++;
    check_eq("w1_diff", 64'(diff1), 64'(m1_diff));
    check_eq("w1_bin", 64'(bin1), 64'(m1_bin));
    check_eq("w1_valid", 64'(vout1), 64'(m1_v));
    check_eq("w8_diff", 64'(diff8), 64'(m8_diff));
    check_eq("w8_bin", 64'(bin8), 64'(m8_bin));
    check_eq("w8_valid", 64'(vout8), 64'(m8_v));
  endtask

  // Truth table as {diff, bin} indexed by {a, b, bout}.
  logic [1:0] tt_exp [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

  initial begin
    logic [2:0] k;
    m1_diff = 1'b0; m1_bin = 1'b0; m1_v = 1'b0;
    m8_diff = 8'h00; m8_bin = 1'b0; m8_v = 1'b0;

    // Reset with live inputs presented; they must be discarded.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1);
    check_eq("rst_release_diff", 64'(diff8), 64'h0);
    check_eq("rst_release_valid", 64'(vout1), 64'h0);

    // Truth table, one beat at a time with an idle cycle between.
    for (int i = 0; i < 8; i++) begin
      k = 3'(i);
      cycle(1'b0, 1'b1, k[2], k[1], k[0], 1'b0, 8'h00, 8'h00, 1'b0);
      check_eq("tt", 64'({diff1, bin1}), 64'(tt_exp[i]));
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    end

    // Streaming: eight back-to-back beats, valid_out high exactly eight cycles.
    v1_count = 0;
    for (int i = 0; i < 8; i++) begin
      k = 3'(i);
      cycle(1'b0, 1'b1, k[2], k[1], k[0], 1'b0, 8'h00, 8'h00, 1'b0);
      check_eq("stream", 64'({diff1, bin1}), 64'(tt_exp[i]));
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check_eq("stream_count", 64'(v1_count), 64'd8);

    // Hold: idle beat with different inputs leaves the result in place.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check_eq("hold_diff", 64'(diff1), 64'h1);
    check_eq("hold_bin", 64'(bin1), 64'h1);
    check_eq("hold_valid", 64'(vout1), 64'h0);

    // Wide boundaries.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b1);
    check_eq("w8_zero_minus_max", 64'({bin8, diff8}), 64'h100);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 8'h01, 1'b0);
    check_eq("w8_msb_borrow", 64'({bin8, diff8}), 64'h07F);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h5A, 1'b0);
    check_eq("w8_equal", 64'({bin8, diff8}), 64'h000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h5A, 1'b1);
    check_eq("w8_equal_bin", 64'({bin8, diff8}), 64'h1FF);

    // Randomized beats on both widths, valid mostly high.
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b0,
            ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Reset lands while a beat is in flight; its result never appears.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'h01, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check_eq("midrst_w8", 64'({vout8, bin8, diff8}), 64'h0);
    check_eq("midrst_w1", 64'({vout1, bin1, diff1}), 64'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check_eq("midrst_after", 64'({vout8, bin8, diff8}), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
